// File: rtl/vga_pkg.sv
// Shared types for the VGA frame scheduler: tile codes, map bounds,
// tile-write record, scheduler states and small helpers.
package vga_pkg;

  localparam int MAP_ROWS = 12;
  localparam int MAP_COLS = 17;

  localparam logic [7:0] BDR = 8'd0;
  localparam logic [7:0] SKY = 8'd1;
  localparam logic [7:0] BLK = 8'd2;
  localparam logic [7:0] GND = 8'd3;

  typedef struct packed {
    logic [3:0] row;
    logic [4:0] col;
    logic [7:0] val;
  } tile_wr_t;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    DRAIN,
    DONE
  } sched_state_t;

  function automatic logic in_map(tile_wr_t t);
    return (t.row < 4'(MAP_ROWS)) && (t.col < 5'(MAP_COLS));
  endfunction

  function automatic logic [31:0] clamp_u32(
    logic [31:0] v,
    logic [31:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// Tile-write request channel between one requester and the scheduler.
// The requester holds req and the payload until ack is seen high.
interface vga_frame_scheduler_if;

  logic       req;
  logic [3:0] row;
  logic [4:0] col;
  logic [7:0] val;
  logic       ack;

  modport master (
    output req,
    output row,
    output col,
    output val,
    input  ack
  );

  modport slave (
    input  req,
    input  row,
    input  col,
    input  val,
    output ack
  );

endinterface

// File: rtl/tile_wr_fifo.sv
// Small synchronous FIFO of pending tile writes; head is read
// combinationally so a full FIFO can pop and push in the same cycle.
module tile_wr_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  tile_wr_t din,
  input  logic     pop,
  output tile_wr_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  tile_wr_t mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Arbitrates tile writes from game logic (A) and scroll engine (B) and
// commits them plus the Mario position only during vertical blanking.
module vga_frame_scheduler
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_WR_PER_VB = 8,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int MARIO_WIDTH   = 42,
  parameter int RESET_X       = 40,
  parameter int RESET_Y       = 360
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblank,
  vga_frame_scheduler_if.slave a,
  vga_frame_scheduler_if.slave b,
  input  logic        pos_valid,
  input  logic [31:0] pos_x,
  input  logic [31:0] pos_y,
  output logic        tile_we,
  output logic [3:0]  tile_row,
  output logic [4:0]  tile_col,
  output logic [7:0]  tile_val,
  output logic [31:0] mario_x,
  output logic [31:0] mario_y,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam logic [31:0] X_MAX =
    32'(SCREEN_WIDTH - MARIO_WIDTH - 1);
  localparam logic [31:0] Y_MAX =
    32'(SCREEN_HEIGHT - MARIO_WIDTH - 1);
  localparam logic [7:0]  WR_MAX = 8'(MAX_WR_PER_VB);

  sched_state_t state;

  logic        vblank_q;
  logic        rr_b;
  logic [7:0]  wr_cnt;
  logic [31:0] shadow_x;
  logic [31:0] shadow_y;

  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        room;
  logic        a_ok;
  logic        b_ok;
  logic        grant_a;
  logic        grant_b;
  logic        grant;
  tile_wr_t    req_ent;
  tile_wr_t    head;

  // A pop in this cycle frees a slot, so a full FIFO can still accept.
  assign pop  = (state == DRAIN) && vblank && !empty &&
                (wr_cnt < WR_MAX);
  assign room = !full || pop;

  assign a_ok    = a.req && room;
  assign b_ok    = b.req && room;
  assign grant_a = a_ok && (!b_ok || !rr_b);
  assign grant_b = b_ok && (!a_ok || rr_b);
  assign grant   = grant_a || grant_b;

  assign a.ack = grant_a;
  assign b.ack = grant_b;

  always_comb begin
    req_ent = '0;
    unique case (1'b1)
      grant_a: req_ent = {a.row, a.col, a.val};
      grant_b: req_ent = {b.row, b.col, b.val};
      default: req_ent = '0;
    endcase
  end

  assign push = grant && in_map(req_ent);
  assign busy = (state != IDLE);

  tile_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (req_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_b     <= 1'b0;
      drop_cnt <= '0;
      shadow_x <= 32'(RESET_X);
      shadow_y <= 32'(RESET_Y);
    end else begin
      if (grant) rr_b <= !rr_b;
      if (grant && !push && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (pos_valid) begin
        shadow_x <= clamp_u32(pos_x, X_MAX);
        shadow_y <= clamp_u32(pos_y, Y_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      vblank_q <= 1'b0;
      wr_cnt   <= '0;
      tile_we  <= 1'b0;
      tile_row <= '0;
      tile_col <= '0;
      tile_val <= '0;
      mario_x  <= 32'(RESET_X);
      mario_y  <= 32'(RESET_Y);
    end else begin
      vblank_q <= vblank;
      tile_we  <= pop;
      if (pop) begin
        {tile_row, tile_col, tile_val} <= head;
        wr_cnt <= wr_cnt + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (vblank && !vblank_q) state <= COMMIT;
        end
        COMMIT: begin
          mario_x <= shadow_x;
          mario_y <= shadow_y;
          wr_cnt  <= '0;
          state   <= DRAIN;
        end
        DRAIN: begin
          if (!pop) state <= DONE;
        end
        DONE: begin
          if (!vblank) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler: directed frames, tables and random
// traffic checked cycle by cycle against a queue-based reference.
module tb_vga_frame_scheduler;
  import vga_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXW  = 8;
  localparam logic [31:0] XLIM  = 32'd597;
  localparam logic [31:0] YLIM  = 32'd437;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ex;
    logic [31:0] ey;
  } clamp_vec_t;

  typedef struct {
    logic [3:0] row;
    logic [4:0] col;
    int         drop_inc;
  } range_vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vblank = 1'b0;
  logic        pos_valid = 1'b0;
  logic [31:0] pos_x = '0;
  logic [31:0] pos_y = '0;
  logic        tile_we;
  logic [3:0]  tile_row;
  logic [4:0]  tile_col;
  logic [7:0]  tile_val;
  logic [31:0] mario_x;
  logic [31:0] mario_y;
  logic        busy;
  logic [7:0]  drop_cnt;

  vga_frame_scheduler_if ai ();
  vga_frame_scheduler_if bi ();

  always #5 clk = ~clk;

  vga_frame_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .vblank    (vblank),
    .a         (ai),
    .b         (bi),
    .pos_valid (pos_valid),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .tile_we   (tile_we),
    .tile_row  (tile_row),
    .tile_col  (tile_col),
    .tile_val  (tile_val),
    .mario_x   (mario_x),
    .mario_y   (mario_y),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  tile_wr_t    m_q[$];
  bit          m_rr_b, m_busy, m_commit, m_drain, m_prev_vb, m_we;
  int          m_issued, m_drop;
  tile_wr_t    m_tile;
  logic [31:0] m_sx, m_sy, m_mx, m_my;

  bit          cap_a, cap_b;
  int          we_seen;
  logic [3:0]  seen_rows[$];
  int          na, nb, exp_drop, exp_wr;
  clamp_vec_t  cv[6];
  range_vec_t  rv[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lim(logic [31:0] v,
                                      logic [31:0] m);
    return (v > m) ? m : v;
  endfunction

  task automatic m_init();
    m_q.delete();
    m_rr_b = 0; m_busy = 0; m_commit = 0; m_drain = 0;
    m_prev_vb = 0; m_we = 0; m_issued = 0; m_drop = 0;
    m_tile = '0;
    m_sx = 32'd40; m_sy = 32'd360;
    m_mx = 32'd40; m_my = 32'd360;
  endtask

  // one clock: predict acks, compare, advance model, compare outputs
  task automatic step();
    bit pop_now, room, wa, wb;
    tile_wr_t ea, eb, e;
    pop_now = m_drain && vblank && (m_q.size() > 0) &&
              (m_issued < MAXW);
    room = (m_q.size() < DEPTH) || pop_now;
    wa = ai.req && room && (!(bi.req && room) || !m_rr_b);
    wb = bi.req && room && !wa;
    ea = {ai.row, ai.col, ai.val};
    eb = {bi.row, bi.col, bi.val};
    #2;
    cap_a = ai.ack;
    cap_b = bi.ack;
    if (!reset) begin
      chk("a_ack", 32'(ai.ack), 32'(wa));
      chk("b_ack", 32'(bi.ack), 32'(wb));
    end
    @(posedge clk);
    if (reset) begin
      m_init();
    end else begin
      if (pop_now) begin
        m_tile = m_q.pop_front();
        m_we = 1;
        m_issued++;
      end else begin
        m_we = 0;
      end
      if (wa || wb) begin
        e = wa ? ea : eb;
        if (e.row < 4'd12 && e.col < 5'd17) m_q.push_back(e);
        else if (m_drop < 255) m_drop++;
        m_rr_b = !m_rr_b;
      end
      if (!m_busy) begin
        if (vblank && !m_prev_vb) begin
          m_busy = 1;
          m_commit = 1;
        end
      end else if (m_commit) begin
        m_mx = m_sx;
        m_my = m_sy;
        m_commit = 0;
        m_drain = 1;
        m_issued = 0;
      end else if (m_drain) begin
        if (!pop_now) m_drain = 0;
      end else if (!vblank) begin
        m_busy = 0;
      end
      if (pos_valid) begin
        m_sx = lim(pos_x, XLIM);
        m_sy = lim(pos_y, YLIM);
      end
      m_prev_vb = vblank;
    end
    #1;
    if (tile_we === 1'b1) begin
      we_seen++;
      seen_rows.push_back(tile_row);
    end
    chk("tile_we", 32'(tile_we), 32'(m_we));
    chk("tile_row", 32'(tile_row), 32'(m_tile.row));
    chk("tile_col", 32'(tile_col), 32'(m_tile.col));
    chk("tile_val", 32'(tile_val), 32'(m_tile.val));
    chk("mario_x", mario_x, m_mx);
    chk("mario_y", mario_y, m_my);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic do_reset();
    reset = 1; vblank = 0; pos_valid = 0;
    ai.req = 0; bi.req = 0;
    step();
    reset = 0;
  endtask

  task automatic frame(input int hi, input int lo);
    vblank = 1;
    repeat (hi) step();
    vblank = 0;
    repeat (lo) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t",
             $time);
    $fatal(1, "timeout");
  end

  initial begin
    cv[0] = '{32'd700, 32'd10, 32'd597, 32'd10};
    cv[1] = '{32'd597, 32'd437, 32'd597, 32'd437};
    cv[2] = '{32'd598, 32'd438, 32'd597, 32'd437};
    cv[3] = '{32'd0, 32'd0, 32'd0, 32'd0};
    cv[4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd597, 32'd437};
    cv[5] = '{32'd596, 32'd436, 32'd596, 32'd436};
    rv[0] = '{4'd11, 5'd16, 0};
    rv[1] = '{4'd12, 5'd0, 1};
    rv[2] = '{4'd0, 5'd17, 1};
    rv[3] = '{4'd15, 5'd31, 1};
    rv[4] = '{4'd0, 5'd0, 0};
    rv[5] = '{4'd11, 5'd17, 1};

    m_init();
    ai.req = 0; ai.row = 0; ai.col = 0; ai.val = 0;
    bi.req = 0; bi.row = 0; bi.col = 0; bi.val = 0;

    // reset state
    do_reset();
    step();
    chk("rst_mario_x", mario_x, 32'd40);
    chk("rst_mario_y", mario_y, 32'd360);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tile_we", 32'(tile_we), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // single write waits for vblank
    ai.req = 1; ai.row = 4'd2; ai.col = 5'd5; ai.val = GND;
    step();
    chk("w1_a_ack", 32'(cap_a), 32'd1);
    ai.req = 0;
    we_seen = 0;
    repeat (5) step();
    chk("w1_no_we_idle", 32'(we_seen), 32'd0);
    vblank = 1;
    step();
    step();
    chk("w1_no_we_early", 32'(we_seen), 32'd0);
    step();
    chk("w1_we", 32'(tile_we), 32'd1);
    chk("w1_row", 32'(tile_row), 32'd2);
    chk("w1_col", 32'(tile_col), 32'd5);
    chk("w1_val", 32'(tile_val), 32'd3);
    vblank = 0;
    repeat (4) step();

    // round robin under contention until the FIFO fills
    do_reset();
    na = 0; nb = 0;
    ai.req = 1; ai.row = 4'd1; ai.col = 5'd1; ai.val = 8'd1;
    bi.req = 1; bi.row = 4'd2; bi.col = 5'd2; bi.val = 8'd2;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_a_ack", 32'(cap_a), 32'(i < 4 && i % 2 == 0));
      chk("rr_b_ack", 32'(cap_b), 32'(i < 4 && i % 2 == 1));
      if (cap_a) begin
        na++;
        ai.row = 4'(1 + 2 * na);
        ai.col = 5'(1 + 2 * na);
        ai.val = 8'(1 + 2 * na);
      end
      if (cap_b) begin
        nb++;
        bi.row = 4'(2 + 2 * nb);
        bi.col = 5'(2 + 2 * nb);
        bi.val = 8'(2 + 2 * nb);
      end
    end
    ai.req = 0; bi.req = 0;

    // short vblank: two writes now, two next frame, in order
    we_seen = 0; seen_rows.delete();
    frame(4, 6);
    chk("part_cnt1", 32'(we_seen), 32'd2);
    chk("part_row0", 32'(seen_rows[0]), 32'd1);
    chk("part_row1", 32'(seen_rows[1]), 32'd2);
    we_seen = 0; seen_rows.delete();
    frame(12, 4);
    chk("part_cnt2", 32'(we_seen), 32'd2);
    chk("part_row2", 32'(seen_rows[0]), 32'd3);
    chk("part_row3", 32'(seen_rows[1]), 32'd4);

    // position clamp, and a strobe during COMMIT lands next frame
    pos_valid = 1; pos_x = 32'd700; pos_y = 32'd10;
    step();
    pos_valid = 0;
    vblank = 1;
    step();
    pos_valid = 1; pos_x = 32'd100; pos_y = 32'd200;
    step();
    pos_valid = 0;
    chk("pos_x_commit", mario_x, 32'd597);
    chk("pos_y_commit", mario_y, 32'd10);
    repeat (2) step();
    vblank = 0;
    repeat (3) step();
    chk("pos_x_held", mario_x, 32'd597);
    frame(3, 3);
    chk("pos_x_late", mario_x, 32'd100);
    chk("pos_y_late", mario_y, 32'd200);

    foreach (cv[i]) begin
      pos_valid = 1; pos_x = cv[i].x; pos_y = cv[i].y;
      step();
      pos_valid = 0;
      frame(3, 2);
      chk("clamp_x", mario_x, cv[i].ex);
      chk("clamp_y", mario_y, cv[i].ey);
    end

    // range check
    do_reset();
    bi.req = 1; bi.row = 4'd12; bi.col = 5'd3; bi.val = SKY;
    step();
    bi.req = 0;
    chk("oor_b_ack", 32'(cap_b), 32'd1);
    chk("oor_drop", 32'(drop_cnt), 32'd1);
    we_seen = 0;
    frame(6, 2);
    chk("oor_no_write", 32'(we_seen), 32'd0);

    exp_drop = 1; exp_wr = 0;
    foreach (rv[i]) begin
      ai.req = 1; ai.row = rv[i].row; ai.col = rv[i].col;
      ai.val = BLK;
      step();
      ai.req = 0;
      exp_drop += rv[i].drop_inc;
      if (rv[i].drop_inc == 0) exp_wr++;
      chk("range_ack", 32'(cap_a), 32'd1);
      chk("range_drop", 32'(drop_cnt), 32'(exp_drop));
    end
    we_seen = 0;
    frame(8, 2);
    chk("range_writes", 32'(we_seen), 32'(exp_wr));

    // drop counter saturates
    ai.req = 1; ai.row = 4'd15; ai.col = 5'd0;
    repeat (260) step();
    ai.req = 0;
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // write budget per vblank, with push while full and popping
    do_reset();
    na = 0;
    ai.req = 1; ai.row = 4'd0; ai.col = 5'd0; ai.val = BDR;
    repeat (4) begin
      step();
      if (cap_a) begin
        na++;
        ai.row = 4'(na % 12); ai.col = 5'(na);
      end
    end
    we_seen = 0;
    vblank = 1;
    repeat (20) begin
      step();
      if (cap_a) begin
        na++;
        ai.row = 4'(na % 12); ai.col = 5'(na % 17);
      end
    end
    ai.req = 0;
    vblank = 0;
    repeat (3) step();
    chk("budget_writes", 32'(we_seen), 32'(MAXW));

    // reset while draining
    do_reset();
    pos_valid = 1; pos_x = 32'd300; pos_y = 32'd100;
    step();
    pos_valid = 0;
    na = 0;
    ai.req = 1; ai.row = 4'd1; ai.col = 5'd1; ai.val = GND;
    while (na < 3) begin
      step();
      if (cap_a) begin
        na++;
        ai.row = 4'(1 + na); ai.col = 5'(1 + na);
      end
    end
    ai.req = 0;
    vblank = 1;
    step();
    step();
    chk("rd_mario_x", mario_x, 32'd300);
    step();
    chk("rd_we", 32'(tile_we), 32'd1);
    chk("rd_busy", 32'(busy), 32'd1);
    reset = 1;
    step();
    reset = 0;
    vblank = 0;
    chk("rd_we_after", 32'(tile_we), 32'd0);
    chk("rd_busy_after", 32'(busy), 32'd0);
    chk("rd_mario_x_after", mario_x, 32'd40);
    step();
    we_seen = 0;
    frame(8, 2);
    chk("rd_fifo_empty", 32'(we_seen), 32'd0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!ai.req || cap_a) begin
        ai.req = ($urandom_range(0, 2) == 0);
        ai.row = 4'($urandom_range(0, 13));
        ai.col = 5'($urandom_range(0, 18));
        ai.val = 8'($urandom_range(0, 3));
      end
      if (!bi.req || cap_b) begin
        bi.req = ($urandom_range(0, 2) == 0);
        bi.row = 4'($urandom_range(0, 13));
        bi.col = 5'($urandom_range(0, 18));
        bi.val = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) == 0) vblank = !vblank;
      pos_valid = ($urandom_range(0, 15) == 0);
      pos_x = ($urandom_range(0, 1) == 1) ?
              32'($urandom_range(0, 800)) : 32'($urandom);
      pos_y = ($urandom_range(0, 1) == 1) ?
              32'($urandom_range(0, 600)) : 32'($urandom);
      reset = ($urandom_range(0, 799) == 0);
      step();
    end
    reset = 0; pos_valid = 0; ai.req = 0; bi.req = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
